// File: rtl/rc4_mem_init_if.sv
// Write port of the RC4 S-memory initialiser.
// Master drives write/address/data; the arbiter answers with wr_ready.
interface rc4_mem_init_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wr_ready;

  modport master (
    output write,
    output address,
    output data,
    input  wr_ready
  );

  modport slave (
    input  write,
    input  address,
    input  data,
    output wr_ready
  );
endinterface

// File: rtl/rc4_mem_init.sv
// RC4 S-box initialiser: fills DEPTH entries with an identity,
// constant or descending pattern, honouring write backpressure.
module rc4_mem_init #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  input  logic              finished_shuffle,
  output logic              busy,
  output logic              finished,
  rc4_mem_init_if.master    mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] fv_q, fv_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;

  // Mode 11 is reserved and falls back to identity.
  function automatic logic [DATA_W-1:0] pat(
    input logic [ADDR_W-1:0] idx,
    input logic [1:0]        md,
    input logic [DATA_W-1:0] fv
  );
    logic [DATA_W-1:0] r;
    unique case (md)
      2'b01:   r = fv;
      2'b10:   r = DATA_W'(LAST - idx);
      default: r = DATA_W'(idx);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    start_d = start;
    mode_d  = mode_q;
    fv_d    = fv_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    fin_d   = fin_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start && !start_q) begin
          state_d = S_FILL;
          mode_d  = mode;
          fv_d    = fill_val;
          addr_d  = '0;
          write_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = pat('0, mode, fill_val);
        end
      end
      (state_q == S_FILL): begin
        if (abort) begin
          state_d = S_IDLE;
          write_d = 1'b0;
          busy_d  = 1'b0;
        end else if (write_q && mem.wr_ready) begin
          if (addr_q == LAST) begin
            state_d = S_DONE;
            write_d = 1'b0;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            data_d = pat(addr_q + 1'b1, mode_q, fv_q);
          end
        end
      end
      (state_q == S_DONE): begin
        if (finished_shuffle) begin
          state_d = S_IDLE;
          fin_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        busy_d  = 1'b0;
        fin_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      mode_q  <= '0;
      fv_q    <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      fv_q    <= fv_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign mem.write   = write_q;
  assign mem.address = addr_q;
  assign mem.data    = data_q;
  assign busy        = busy_q;
  assign finished    = fin_q;

endmodule
